meta_port_arbiter: RTL and testbench

Arbitrates the single-ported BSR metadata SRAM (row_ptr / col_idx tables) between two read requesters and one write requester. Read requester 0 is the BSR scheduler; read requester 1 is the metadata prefetch/debug reader; the write requester is the DMA metadata loader. The arbiter issues at most one memory operation per cycle and routes each read response back to its issuer. It also supports a flush so that an aborted scheduler never receives stale data.

---
 rtl/meta_port_arbiter.sv | 112 +++++++++++
 tb/tb_meta_port_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/meta_port_arbiter.sv
// Arbiter for the single-ported BSR metadata SRAM: two read requesters, one write
// requester, registered SRAM issue stage and a tag pipe routing read data back.
module meta_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int RD_LAT       = 1,
    parameter int WR_BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              r0_req,
    input  logic [ADDR_W-1:0] r0_addr,
    output logic              r0_gnt,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_rvalid,
    input  logic              r1_req,
    input  logic [ADDR_W-1:0] r1_addr,
    output logic              r1_gnt,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_rvalid,
    input  logic              w_req,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_wdata,
    output logic              w_gnt,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [2:0] BURST_MAX = 3'(WR_BURST_MAX);

    logic [2:0]      wr_streak;
    logic            last_rd;
    logic [RD_LAT:0] tag_vld;
    logic [RD_LAT:0] tag_id;
    logic            rd_pend;
    logic            rd_gnt;
    logic            rsp_hit;

    always_comb begin
        r0_gnt  = 1'b0;
        r1_gnt  = 1'b0;
        w_gnt   = 1'b0;
        rd_pend = r0_req | r1_req;
        if (rst_n && !flush) begin
            // A saturated write streak yields one slot to a pending read.
            if (w_req && !(wr_streak == BURST_MAX && rd_pend)) begin
                w_gnt = 1'b1;
            end else if (r0_req && r1_req) begin
                if (last_rd) r0_gnt = 1'b1;
                else         r1_gnt = 1'b1;
            end else if (r0_req) begin
                r0_gnt = 1'b1;
            end else if (r1_req) begin
                r1_gnt = 1'b1;
            end
        end
        rd_gnt  = r0_gnt | r1_gnt;
        rsp_hit = tag_vld[RD_LAT] & ~flush;
    end

    assign busy = |tag_vld;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_streak <= '0;
            last_rd   <= 1'b1;
            tag_vld   <= '0;
            tag_id    <= '0;
            mem_ren   <= 1'b0;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            r0_rvalid <= 1'b0;
            r1_rvalid <= 1'b0;
            r0_rdata  <= '0;
            r1_rdata  <= '0;
        end else begin
            if (w_gnt && rd_pend) begin
                if (wr_streak != BURST_MAX) wr_streak <= wr_streak + 3'd1;
            end else if (!w_gnt) begin
                wr_streak <= '0;
            end

            if (r0_gnt) last_rd <= 1'b0;
            if (r1_gnt) last_rd <= 1'b1;

            mem_ren <= rd_gnt;
            mem_wen <= w_gnt;
            if (r0_gnt) mem_addr <= r0_addr;
            if (r1_gnt) mem_addr <= r1_addr;
            if (w_gnt) begin
                mem_addr  <= w_addr;
                mem_wdata <= w_wdata;
            end

            // Entry RD_LAT lines up with the cycle mem_rdata answers that read.
            tag_vld <= {tag_vld[RD_LAT-1:0], rd_gnt} & {(RD_LAT+1){~flush}};
            tag_id  <= {tag_id[RD_LAT-1:0], r1_gnt};

            r0_rvalid <= rsp_hit & ~tag_id[RD_LAT];
            r1_rvalid <= rsp_hit &  tag_id[RD_LAT];
            if (rsp_hit && !tag_id[RD_LAT]) r0_rdata <= mem_rdata;
            if (rsp_hit &&  tag_id[RD_LAT]) r1_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_meta_port_arbiter.sv
// Bench for meta_port_arbiter: directed scenarios on an RD_LAT=1 instance and a
// randomized scoreboard run on an RD_LAT=3 instance sharing the same stimulus.
module tb_meta_port_arbiter;

    localparam int WBM = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush, r0_req, r1_req, w_req;
    logic [31:0] r0_addr, r1_addr, w_addr, w_wdata;

    logic        a_g0, a_g1, a_gw, a_rv0, a_rv1, a_ren, a_wen, a_busy;
    logic [31:0] a_rd0, a_rd1, a_maddr, a_mwdata, a_mrdata;
    logic        b_g0, b_g1, b_gw, b_rv0, b_rv1, b_ren, b_wen, b_busy;
    logic [31:0] b_rd0, b_rd1, b_maddr, b_mwdata, b_mrdata;

    meta_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1), .WR_BURST_MAX(WBM)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .r0_req(r0_req), .r0_addr(r0_addr), .r0_gnt(a_g0), .r0_rdata(a_rd0), .r0_rvalid(a_rv0),
        .r1_req(r1_req), .r1_addr(r1_addr), .r1_gnt(a_g1), .r1_rdata(a_rd1), .r1_rvalid(a_rv1),
        .w_req(w_req), .w_addr(w_addr), .w_wdata(w_wdata), .w_gnt(a_gw),
        .mem_ren(a_ren), .mem_wen(a_wen), .mem_addr(a_maddr), .mem_wdata(a_mwdata),
        .mem_rdata(a_mrdata), .busy(a_busy));

    meta_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3), .WR_BURST_MAX(WBM)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .r0_req(r0_req), .r0_addr(r0_addr), .r0_gnt(b_g0), .r0_rdata(b_rd0), .r0_rvalid(b_rv0),
        .r1_req(r1_req), .r1_addr(r1_addr), .r1_gnt(b_g1), .r1_rdata(b_rd1), .r1_rvalid(b_rv1),
        .w_req(w_req), .w_addr(w_addr), .w_wdata(w_wdata), .w_gnt(b_gw),
        .mem_ren(b_ren), .mem_wen(b_wen), .mem_addr(b_maddr), .mem_wdata(b_mwdata),
        .mem_rdata(b_mrdata), .busy(b_busy));

    // SRAM models: unwritten words read back as their own address.
    logic [31:0] sram_a [logic [31:0]];
    logic [31:0] sram_b [logic [31:0]];
    logic [31:0] a_pipe;
    logic [31:0] b_pipe [3];
    assign a_mrdata = a_pipe;
    assign b_mrdata = b_pipe[2];

    always @(posedge clk) begin
        if (a_wen) sram_a[a_maddr] = a_mwdata;
        if (a_ren) a_pipe <= sram_a.exists(a_maddr) ? sram_a[a_maddr] : a_maddr;
    end

    always @(posedge clk) begin
        if (b_wen) sram_b[b_maddr] = b_mwdata;
        if (b_ren) b_pipe[0] <= sram_b.exists(b_maddr) ? sram_b[b_maddr] : b_maddr;
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
    end

    int passed = 0;
    int total  = 0;

    typedef struct {
        int          due;
        int          id;
        logic [31:0] data;
    } rsp_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        r0_req = 1'b0;
        r1_req = 1'b0;
        w_req  = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0;
        r0_req = 1'b1; r1_req = 1'b1; w_req = 1'b1;
        r0_addr = 32'd1; r1_addr = 32'd2; w_addr = 32'd200; w_wdata = 32'h55;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({a_g0, a_g1, a_gw} !== 3'b000) $display("FAIL reset_gnt cyc=%0d got %b want 000", i, {a_g0, a_g1, a_gw});
            else passed++;
            tick();
        end
        total++;
        if ({a_rv0, a_rv1, a_ren, a_wen, a_busy} !== 5'b0) $display("FAIL reset_ctl got %b want 00000", {a_rv0, a_rv1, a_ren, a_wen, a_busy});
        else passed++;
        total++;
        if ({a_rd0, a_rd1, a_maddr, a_mwdata} !== 128'd0) $display("FAIL reset_data got %h %h %h %h want 0", a_rd0, a_rd1, a_maddr, a_mwdata);
        else passed++;
        total++;
        if ({b_rv0, b_rv1, b_busy} !== 3'b0) $display("FAIL reset_b got %b want 000", {b_rv0, b_rv1, b_busy});
        else passed++;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({a_g0, a_g1, a_gw} !== 3'b001) $display("FAIL release_gnt got %b want 001", {a_g0, a_g1, a_gw});
        else passed++;
        tick();
        idle_inputs();
        total++;
        if ({a_wen, a_ren, a_maddr, a_mwdata} !== {2'b10, 32'd200, 32'h55}) $display("FAIL release_issue got %b %b %h %h want 1 0 c8 55", a_wen, a_ren, a_maddr, a_mwdata);
        else passed++;
        repeat (2) tick();
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_data [6];
        int          exp_id   [6];
        int          j;
        for (int k = 0; k < 11; k++) begin
            if (k < 6) begin
                r0_req = 1'b1; r1_req = 1'b1;
                r0_addr = 32'(16 + k); r1_addr = 32'(32 + k);
                exp_id[k]   = k % 2;
                exp_data[k] = (k % 2 == 1) ? 32'(32 + k) : 32'(16 + k);
                @(negedge clk);
                total++;
                if ({a_g0, a_g1, a_gw} !== ((k % 2 == 1) ? 3'b010 : 3'b100)) $display("FAIL rr_gnt k=%0d got %b", k, {a_g0, a_g1, a_gw});
                else passed++;
            end else begin
                idle_inputs();
            end
            tick();
            j = k - 2;
            total++;
            if (j >= 0 && j < 6) begin
                if ({a_rv0, a_rv1} !== ((exp_id[j] == 1) ? 2'b01 : 2'b10)) $display("FAIL rr_rvalid grant=%0d got %b want id %0d", j, {a_rv0, a_rv1}, exp_id[j]);
                else passed++;
                total++;
                if (((exp_id[j] == 1) ? a_rd1 : a_rd0) !== exp_data[j]) $display("FAIL rr_rdata grant=%0d got %h want %h", j, (exp_id[j] == 1) ? a_rd1 : a_rd0, exp_data[j]);
                else passed++;
            end else begin
                if ({a_rv0, a_rv1} !== 2'b00) $display("FAIL rr_idle_rvalid k=%0d got %b want 00", k, {a_rv0, a_rv1});
                else passed++;
            end
        end
        repeat (2) tick();
    endtask

    task automatic test_write_starve();
        for (int k = 0; k < 11; k++) begin
            if (k < 10) begin
                w_req = 1'b1; r0_req = 1'b1;
                w_addr = 32'd300; w_wdata = 32'(k); r0_addr = 32'd301;
                @(negedge clk);
                total++;
                if ({a_g0, a_g1, a_gw} !== ((k % 5 == 4) ? 3'b100 : 3'b001)) $display("FAIL starve_gnt k=%0d got %b", k, {a_g0, a_g1, a_gw});
                else passed++;
            end else begin
                idle_inputs();
            end
            tick();
            if (k < 10) begin
                total++;
                if ({a_wen, a_ren} !== ((k % 5 == 4) ? 2'b01 : 2'b10)) $display("FAIL starve_issue k=%0d got wen,ren=%b", k, {a_wen, a_ren});
                else passed++;
            end
        end
        total++;
        if ({a_wen, a_ren} !== 2'b00) $display("FAIL starve_idle_issue got %b want 00", {a_wen, a_ren});
        else passed++;
        repeat (6) tick();
    endtask

    task automatic test_read_after_write();
        w_req = 1'b1; w_addr = 32'd130; w_wdata = 32'hDEAD;
        @(negedge clk);
        total++;
        if ({a_g0, a_g1, a_gw} !== 3'b001) $display("FAIL raw_wgnt got %b want 001", {a_g0, a_g1, a_gw});
        else passed++;
        tick();
        w_req = 1'b0; r0_req = 1'b1; r0_addr = 32'd130;
        @(negedge clk);
        total++;
        if ({a_g0, a_g1, a_gw} !== 3'b100) $display("FAIL raw_rgnt got %b want 100", {a_g0, a_g1, a_gw});
        else passed++;
        tick();
        idle_inputs();
        total++;
        if ({a_ren, a_wen} !== 2'b10) $display("FAIL raw_issue got ren,wen=%b want 10", {a_ren, a_wen});
        else passed++;
        tick();
        total++;
        if (a_rv0 !== 1'b0) $display("FAIL raw_early got %b want 0", a_rv0);
        else passed++;
        tick();
        total++;
        if (a_rv0 !== 1'b1) $display("FAIL raw_rvalid got %b want 1", a_rv0);
        else passed++;
        total++;
        if (a_rd0 !== 32'hDEAD) $display("FAIL raw_rdata got %h want dead", a_rd0);
        else passed++;
        repeat (2) tick();
    endtask

    task automatic test_flush();
        r1_req = 1'b1; r1_addr = 32'd40;
        @(negedge clk);
        total++;
        if ({a_g0, a_g1, a_gw} !== 3'b010) $display("FAIL flush_g0 got %b want 010", {a_g0, a_g1, a_gw});
        else passed++;
        tick();
        r1_addr = 32'd41;
        @(negedge clk);
        total++;
        if ({a_g0, a_g1, a_gw} !== 3'b010) $display("FAIL flush_g1 got %b want 010", {a_g0, a_g1, a_gw});
        else passed++;
        tick();
        flush = 1'b1; r1_addr = 32'd99;
        @(negedge clk);
        total++;
        if ({a_g0, a_g1, a_gw, a_busy} !== 4'b0001) $display("FAIL flush_cycle got gnt,busy=%b want 0001", {a_g0, a_g1, a_gw, a_busy});
        else passed++;
        tick();
        flush = 1'b0; r1_addr = 32'd42;
        total++;
        if ({a_busy, a_rv1} !== 2'b00) $display("FAIL flush_after got busy,rv1=%b want 00", {a_busy, a_rv1});
        else passed++;
        @(negedge clk);
        total++;
        if ({a_g0, a_g1, a_gw} !== 3'b010) $display("FAIL flush_regrant got %b want 010", {a_g0, a_g1, a_gw});
        else passed++;
        tick();
        idle_inputs();
        for (int k = 0; k < 2; k++) begin
            total++;
            if (a_rv1 !== 1'b0) $display("FAIL flush_stale k=%0d got %b want 0", k, a_rv1);
            else passed++;
            tick();
        end
        total++;
        if ({a_rv1, a_rd1} !== {1'b1, 32'd42}) $display("FAIL flush_resp got %b %h want 1 2a", a_rv1, a_rd1);
        else passed++;
        repeat (2) tick();
    endtask

    task automatic test_reset_midflight();
        r0_req = 1'b1; r0_addr = 32'd50;
        @(negedge clk);
        total++;
        if ({a_g0, a_g1, a_gw} !== 3'b100) $display("FAIL midrst_gnt got %b want 100", {a_g0, a_g1, a_gw});
        else passed++;
        tick();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++;
        if (a_busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", a_busy);
        else passed++;
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({a_rv0, a_rv1} !== 2'b00) $display("FAIL midrst_rvalid k=%0d got %b want 00", k, {a_rv0, a_rv1});
            else passed++;
            tick();
        end
    endtask

    task automatic test_random();
        logic [31:0] mm [logic [31:0]];
        rsp_t        sb [$];
        rsp_t        r;
        int          streak, last;
        logic        pg0, pg1, pgw, eg0, eg1, egw, rdp;
        logic [1:0]  exp_rv;
        logic [31:0] exp_d, a;
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        streak = 0; last = 1;
        pg0 = 1'b1; pg1 = 1'b1; pgw = 1'b1;
        for (int c = 0; c < 1008; c++) begin
            exp_rv = 2'b00; exp_d = '0;
            if (sb.size() > 0 && sb[0].due == c) begin
                exp_rv = (sb[0].id == 1) ? 2'b01 : 2'b10;
                exp_d  = sb[0].data;
                void'(sb.pop_front());
            end
            total++;
            if ({b_rv0, b_rv1} !== exp_rv) $display("FAIL rand_rvalid c=%0d got %b want %b", c, {b_rv0, b_rv1}, exp_rv);
            else passed++;
            if (exp_rv != 2'b00) begin
                total++;
                if ((exp_rv[1] ? b_rd0 : b_rd1) !== exp_d) $display("FAIL rand_rdata c=%0d got %h want %h", c, exp_rv[1] ? b_rd0 : b_rd1, exp_d);
                else passed++;
            end
            if (c >= 1000) begin
                idle_inputs();
                tick();
                continue;
            end
            if (!r0_req || pg0) begin
                r0_req = ($urandom_range(0, 2) != 0);
                r0_addr = 32'd1000 + 32'($urandom_range(0, 63));
            end
            if (!r1_req || pg1) begin
                r1_req = ($urandom_range(0, 2) != 0);
                r1_addr = 32'd1000 + 32'($urandom_range(0, 63));
            end
            if (!w_req || pgw) begin
                w_req = ($urandom_range(0, 1) != 0);
                w_addr = 32'd1000 + 32'($urandom_range(0, 63));
                w_wdata = $urandom;
            end
            flush = ($urandom_range(0, 39) == 0);
            rdp = r0_req | r1_req;
            eg0 = 1'b0; eg1 = 1'b0; egw = 1'b0;
            if (!flush) begin
                if (w_req && !(streak == WBM && rdp)) egw = 1'b1;
                else if (r0_req && r1_req) begin
                    if (last == 1) eg0 = 1'b1;
                    else           eg1 = 1'b1;
                end
                else if (r0_req) eg0 = 1'b1;
                else if (r1_req) eg1 = 1'b1;
            end
            @(negedge clk);
            total++;
            if ({b_g0, b_g1, b_gw} !== {eg0, eg1, egw}) $display("FAIL rand_gnt c=%0d got %b want %b", c, {b_g0, b_g1, b_gw}, {eg0, eg1, egw});
            else passed++;
            if (egw && rdp) streak = (streak < WBM) ? streak + 1 : streak;
            else if (!egw) streak = 0;
            if (egw) mm[w_addr] = w_wdata;
            if (eg0 || eg1) begin
                a = eg0 ? r0_addr : r1_addr;
                r.due = c + 5; r.id = eg1 ? 1 : 0;
                r.data = mm.exists(a) ? mm[a] : a;
                sb.push_back(r);
                last = eg1 ? 1 : 0;
            end
            if (flush) begin
                while (sb.size() > 0 && sb[sb.size()-1].due > c) void'(sb.pop_back());
            end
            pg0 = eg0; pg1 = eg1; pgw = egw;
            tick();
        end
        total++;
        if (sb.size() != 0) $display("FAIL rand_leftover got %0d pending want 0", sb.size());
        else passed++;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_write_starve();
        test_read_after_write();
        test_flush();
        test_reset_midflight();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
